// File: rtl/f2_shift_pipe_if.sv
// Handshake bundle for f2_shift_pipe: request channel (in_*) and result channel (out_*).
// The master drives requests and accepts results; the slave is the shift unit.
interface f2_shift_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int AMT_W = $clog2(WIDTH);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [1:0]              in_mode;
  logic [AMT_W-1:0]        in_amt;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ovf;
  logic                    out_sticky;

  modport master (
    output in_valid, in_sel, in_mode, in_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_sticky
  );

  modport slave (
    input  in_valid, in_sel, in_mode, in_amt, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_sticky
  );
endinterface

// File: rtl/f2_shift_pipe.sv
// Two-stage operand-select-and-shift unit between the operand mux network and normalise/round.
// Stage 1 captures the selected operand; stage 2 shifts and derives the ovf/sticky flags.
module f2_shift_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3
) (
  input logic            clk,
  input logic            rst_n,
  f2_shift_pipe_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_IN);
  localparam int AMT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MODE_LSL  = 2'b00,
    MODE_LSR  = 2'b01,
    MODE_ASR  = 2'b10,
    MODE_PASS = 2'b11
  } mode_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  mode_e            s1_mode;
  logic [AMT_W-1:0] s1_amt;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_ovf;
  logic             s2_sticky;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] sel_op;
  logic [WIDTH-1:0] hi_mask;
  logic [WIDTH-1:0] lo_mask;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             res_sticky;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign accept       = bus.in_valid && bus.in_ready;

  // Out-of-range selects fall through to the all-zero default.
  always_comb begin
    sel_op = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) sel_op = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= MODE_PASS;
      s1_amt   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_data  <= sel_op;
      s1_mode  <= mode_e'(bus.in_mode);
      s1_amt   <= bus.in_amt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // hi_mask covers the amt bits pushed out by a left shift, lo_mask those pushed out
  // by a right shift; both are empty when amt is zero, which keeps the flags clear.
  always_comb begin
    hi_mask    = ~({WIDTH{1'b1}} >> s1_amt);
    lo_mask    = ~({WIDTH{1'b1}} << s1_amt);
    res_data   = s1_data;
    res_ovf    = 1'b0;
    res_sticky = 1'b0;
    case (s1_mode)
      MODE_LSL: begin
        res_data = s1_data << s1_amt;
        res_ovf  = |(s1_data & hi_mask);
      end
      MODE_LSR: begin
        res_data   = s1_data >> s1_amt;
        res_sticky = |(s1_data & lo_mask);
      end
      MODE_ASR: begin
        res_data   = $unsigned($signed(s1_data) >>> s1_amt);
        res_sticky = |(s1_data & lo_mask);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_ovf    <= 1'b0;
      s2_sticky <= 1'b0;
    end else if (s1_adv) begin
      s2_valid  <= 1'b1;
      s2_data   <= res_data;
      s2_ovf    <= res_ovf;
      s2_sticky <= res_sticky;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_ovf    = s2_ovf;
  assign bus.out_sticky = s2_sticky;
endmodule

// File: tb/tb_f2_shift_pipe.sv
// Self-checking bench for f2_shift_pipe: a bit-level reference model feeds an in-order
// expectation queue, and directed vectors pin literal results, latency, stalls and reset.
module tb_f2_shift_pipe;
  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = $clog2(NUM_IN);
  localparam int AMT_W  = $clog2(WIDTH);

  localparam logic [1:0] LSL  = 2'b00;
  localparam logic [1:0] LSR  = 2'b01;
  localparam logic [1:0] ASR  = 2'b10;
  localparam logic [1:0] PASS = 2'b11;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   lastWait = 0;

  logic [WIDTH+1:0] expQ[$];
  logic             stallHeld = 1'b0;
  logic [WIDTH+1:0] heldOut;

  f2_shift_pipe_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) bus ();

  f2_shift_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Result built bit by bit from where each output bit comes from; returns {ovf, sticky, data}.
  function automatic logic [WIDTH+1:0] model(input logic [SEL_W-1:0] sel, input logic [1:0] mode,
                                             input logic [AMT_W-1:0] amt,
                                             input logic [NUM_IN*WIDTH-1:0] data);
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] r;
    logic             ovf;
    logic             sticky;
    int               a;
    op     = '0;
    ovf    = 1'b0;
    sticky = 1'b0;
    a      = int'(amt);
    if (int'(sel) < NUM_IN) op = data[int'(sel)*WIDTH +: WIDTH];
    r = op;
    if (mode != PASS && a != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (mode == LSL)      r[i] = (i >= a) ? op[i-a] : 1'b0;
        else if (mode == LSR) r[i] = (i + a < WIDTH) ? op[i+a] : 1'b0;
        else                  r[i] = (i + a < WIDTH) ? op[i+a] : op[WIDTH-1];
      end
      for (int i = 0; i < a; i++) begin
        if (mode == LSL && op[WIDTH-1-i]) ovf = 1'b1;
        if (mode != LSL && op[i])         sticky = 1'b1;
      end
    end
    return {ovf, sticky, r};
  endfunction

  task automatic compareVal(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare process: every delivered result must match the oldest outstanding model entry,
  // and a stalled result must not change until it is taken.
  always @(negedge clk) begin
    if (!rst_n) begin
      expQ.delete();
      stallHeld <= 1'b0;
    end else begin
      if (stallHeld) begin
        compareVal("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        compareVal("stall_data", bus.out_data, heldOut[WIDTH-1:0]);
        compareVal("stall_flags", {30'd0, bus.out_ovf, bus.out_sticky}, {30'd0, heldOut[WIDTH+1:WIDTH]});
      end
      if (bus.out_valid && bus.out_ready) begin
        stallHeld <= 1'b0;
        if (expQ.size() == 0) begin
          compareVal("unexpected_output", bus.out_data, 32'hxxxx_xxxx);
        end else begin
          logic [WIDTH+1:0] e;
          e = expQ.pop_front();
          compareVal("model_data", bus.out_data, e[WIDTH-1:0]);
          compareVal("model_flags", {30'd0, bus.out_ovf, bus.out_sticky}, {30'd0, e[WIDTH+1:WIDTH]});
        end
      end else if (bus.out_valid) begin
        stallHeld <= 1'b1;
        heldOut   <= {bus.out_ovf, bus.out_sticky, bus.out_data};
      end else begin
        stallHeld <= 1'b0;
      end
      if (bus.in_valid && bus.in_ready)
        expQ.push_back(model(bus.in_sel, bus.in_mode, bus.in_amt, bus.in_data));
    end
  end

  task automatic setReq(input logic [SEL_W-1:0] sel, input logic [1:0] mode, input logic [AMT_W-1:0] amt,
                        input logic [WIDTH-1:0] op);
    bus.in_sel  = sel;
    bus.in_mode = mode;
    bus.in_amt  = amt;
    for (int k = 0; k < NUM_IN; k++)
      bus.in_data[k*WIDTH +: WIDTH] = (k == int'(sel)) ? op : (32'hA5A5_0F00 | 32'(k + 1));
  endtask

  task automatic setIdx(input int i);
    setReq(SEL_W'(i % NUM_IN), 2'(i), AMT_W'(i * 7 + 1), 32'h9357_1BDF ^ (32'(i) * 32'h1111_0101));
  endtask

  // Presents one request and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [SEL_W-1:0] sel, input logic [1:0] mode,
                               input logic [AMT_W-1:0] amt, input logic [WIDTH-1:0] op);
    int n = 0;
    @(posedge clk); #1;
    setReq(sel, mode, amt, op);
    bus.in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 20);
    if (!bus.in_ready) compareVal("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expData,
                             input logic expOvf, input logic expSticky);
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.out_valid && waited < 10);
    lastWait = waited;
    compareVal({name, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    compareVal({name, "_data"}, bus.out_data, expData);
    compareVal({name, "_flags"}, {30'd0, bus.out_ovf, bus.out_sticky}, {30'd0, expOvf, expSticky});
  endtask

  task automatic checkIdle(input string name);
    compareVal({name, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    compareVal({name, "_out_data"}, bus.out_data, 32'd0);
    compareVal({name, "_flags"}, {30'd0, bus.out_ovf, bus.out_sticky}, 32'd0);
    compareVal({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic waitDrain(input string name);
    int n = 0;
    while ((expQ.size() != 0 || bus.out_valid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    compareVal({name, "_outstanding"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] validHist;
    int         accepts;
    int         n;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    setReq('0, LSL, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkIdle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(2'd0, LSL, 5'd3, 32'h0000_0005);
    checkOutput("lsl3", 32'h0000_0028, 1'b0, 1'b0);
    compareVal("latency", 32'(lastWait), 32'd2);
    applyStimulus(2'd2, LSL, 5'd1, 32'hF000_0000);
    checkOutput("lsl1_ovf", 32'hE000_0000, 1'b1, 1'b0);
    applyStimulus(2'd2, PASS, 5'd1, 32'hF000_0000);
    checkOutput("pass", 32'hF000_0000, 1'b0, 1'b0);
    applyStimulus(2'd1, ASR, 5'd1, 32'h8000_0001);
    checkOutput("asr1", 32'hC000_0000, 1'b0, 1'b1);
    applyStimulus(2'd0, LSR, 5'd4, 32'h8000_0010);
    checkOutput("lsr4", 32'h0800_0001, 1'b0, 1'b0);
    applyStimulus(2'd3, LSL, 5'd4, 32'h1234_5678);
    checkOutput("sel_oob", 32'h0000_0000, 1'b0, 1'b0);
    applyStimulus(2'd1, LSL, 5'd0, 32'h8000_0001);
    checkOutput("amt0_lsl", 32'h8000_0001, 1'b0, 1'b0);
    applyStimulus(2'd0, ASR, 5'd0, 32'h8000_0001);
    checkOutput("amt0_asr", 32'h8000_0001, 1'b0, 1'b0);
    applyStimulus(2'd0, LSL, 5'd31, 32'h0000_0003);
    checkOutput("lsl31", 32'h8000_0000, 1'b1, 1'b0);
    applyStimulus(2'd2, LSR, 5'd31, 32'hFFFF_FFFF);
    checkOutput("lsr31", 32'h0000_0001, 1'b0, 1'b1);
    applyStimulus(2'd1, ASR, 5'd31, 32'h8000_0000);
    checkOutput("asr31", 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(2'd2, ASR, 5'd8, 32'h7F00_00FF);
    checkOutput("asr8", 32'h007F_0000, 1'b0, 1'b1);
    waitDrain("directed");

    // Back-to-back: four requests, results on four consecutive cycles.
    validHist = '0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) setIdx(i);
      else bus.in_valid = 1'b0;
      @(negedge clk);
      validHist[i] = bus.out_valid;
      if (i < 4) compareVal("b2b_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    compareVal("b2b_valid_pattern", {24'd0, validHist}, 32'h0000_003C);
    waitDrain("b2b");

    // Backpressure: only two requests fit while the output is blocked.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    accepts       = 0;
    setIdx(10);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        accepts++;
        @(posedge clk); #1;
        setIdx(10 + accepts);
      end else begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    compareVal("stall_accepts", 32'(accepts), 32'd2);
    compareVal("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 20);
    compareVal("release_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    waitDrain("release");

    // Reset with both stages full: the two requests must vanish.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    setIdx(20);
    repeat (2) begin
      @(posedge clk); #1;
      setIdx(21);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    compareVal("full_before_reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("mid_reset");
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    repeat (6) @(negedge clk);
    compareVal("post_reset_quiet", {31'd0, bus.out_valid}, 32'd0);
    applyStimulus(2'd1, LSR, 5'd2, 32'h0000_000F);
    checkOutput("post_reset_lsr2", 32'h0000_0003, 1'b0, 1'b1);
    waitDrain("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
